alu_cmd_seq: RTL

Command sequencer that sits directly upstream of `alu` and captures its results. It buffers operand/opcode commands in a small FIFO and presents the head entry to the combinational `alu`. It then registers the ALU result and flags into an output stage with a valid/ready handshake. Consumers get a pipelined, back-pressurable ALU with throughput of one operation per cycle.

---
 rtl/alu_cmd_seq_if.sv | 27 ++
 rtl/alu_cmd_seq.sv | 101 ++++++++++
 2 files changed

// File: rtl/alu_cmd_seq_if.sv
// Command and result handshake bundle between a producer/consumer and alu_cmd_seq.
interface alu_cmd_seq_if #(
  parameter int unsigned WIDTH = 4
) ();
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic             cmd_c;
  logic [WIDTH-1:0] cmd_x;
  logic [WIDTH-1:0] cmd_y;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_s;
  logic             res_c;
  logic             res_zero;
  logic             res_overflow;

  modport master (
    output cmd_valid, cmd_op, cmd_c, cmd_x, cmd_y, res_ready,
    input  cmd_ready, res_valid, res_s, res_c, res_zero, res_overflow
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_c, cmd_x, cmd_y, res_ready,
    output cmd_ready, res_valid, res_s, res_c, res_zero, res_overflow
  );
endinterface

// File: rtl/alu_cmd_seq.sv
// Command FIFO in front of a combinational ALU, with a registered valid/ready result stage.
// One operation per cycle when neither side stalls.
module alu_cmd_seq #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  alu_cmd_seq_if.slave             bus,
  output logic [2:0]               alu_op,
  output logic                     alu_in_c,
  output logic [WIDTH-1:0]         alu_in_x,
  output logic [WIDTH-1:0]         alu_in_y,
  input  logic [WIDTH-1:0]         alu_s,
  input  logic                     alu_c,
  input  logic                     alu_zero,
  input  logic                     alu_overflow,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef struct packed {
    logic [2:0]       op;
    logic             c;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          issue;
  logic          empty;

  // Ready comes from registered occupancy only; a same-cycle pop never frees a slot early.
  assign bus.cmd_ready = (count != CW'(DEPTH));
  assign empty         = (count == '0);
  assign push          = bus.cmd_valid && bus.cmd_ready;
  assign issue         = !empty && (!bus.res_valid || bus.res_ready);
  assign head          = mem[rd_ptr];

  // Head entry drives the ALU; idle inputs are forced to zero when empty.
  always_comb begin
    alu_op   = '0;
    alu_in_c = 1'b0;
    alu_in_x = '0;
    alu_in_y = '0;
    if (!empty) begin
      alu_op   = head.op;
      alu_in_c = head.c;
      alu_in_x = head.x;
      alu_in_y = head.y;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{op: bus.cmd_op, c: bus.cmd_c, x: bus.cmd_x, y: bus.cmd_y};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + AW'(1);
      if (issue) rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, issue})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Result stage: capture on issue, retire on handshake, hold under back-pressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.res_valid    <= 1'b0;
      bus.res_s        <= '0;
      bus.res_c        <= 1'b0;
      bus.res_zero     <= 1'b0;
      bus.res_overflow <= 1'b0;
    end else if (issue) begin
      bus.res_valid    <= 1'b1;
      bus.res_s        <= alu_s;
      bus.res_c        <= alu_c;
      bus.res_zero     <= alu_zero;
      bus.res_overflow <= alu_overflow;
    end else if (bus.res_valid && bus.res_ready) begin
      bus.res_valid    <= 1'b0;
    end
  end

endmodule
